main_control: RTL and testbench

//   Main control decoder for the single-cycle MIPS datapath.
//   - Maps the 6-bit instruction opcode to the datapath steering signals: RegDst, ALUSrc, MemToReg,

---
 rtl/main_control.sv | 66 ++++++
 tb/tb_main_control.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/main_control.sv
// Single-cycle MIPS main control decoder with a sticky illegal-opcode flag.
// Optional addi support is compiled in when the macro CONTROL_ADDI_EN is defined.
module main_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OpCode,
  output logic       RegDst,
  output logic       ALUSrc,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Branch,
  output logic       ALUOp1,
  output logic       ALUOp0,
  output logic       IllegalOp
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef CONTROL_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  // Bit order: RegDst ALUSrc MemToReg RegWrite MemRead MemWrite Branch ALUOp1 ALUOp0
  logic [8:0] ctrl_d;
  logic       supported_d;
  logic       illegal_q;
  logic       illegal_d;

  // An X/Z opcode matches no case item, so it lands in default and is unsupported.
  always_comb begin
    ctrl_d      = 9'b0;
    supported_d = 1'b1;
    case (OpCode)
      OP_RTYPE: ctrl_d = 9'b100100010;
      OP_LW:    ctrl_d = 9'b011110000;
      OP_SW:    ctrl_d = 9'b010001000;
      OP_BEQ:   ctrl_d = 9'b000000101;
`ifdef CONTROL_ADDI_EN
      OP_ADDI:  ctrl_d = 9'b010100000;
`endif
      default:  supported_d = 1'b0;
    endcase
    if (rst) begin
      ctrl_d = 9'b0;
    end
  end

  assign {RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp1, ALUOp0} = ctrl_d;

  assign illegal_d = illegal_q | ~supported_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign IllegalOp = illegal_q;

endmodule

// File: tb/tb_main_control.sv
// Self-checking bench for main_control: directed scenarios plus randomized opcodes
// compared against an instruction-level reference model.
`timescale 1ns/1ps
module tb_main_control;

  logic       clk;
  logic       rst;
  logic [5:0] OpCode;
  logic       RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp1, ALUOp0;
  logic       IllegalOp;
  logic [8:0] ctrl;

  int errors = 0;
  int checks = 0;
  logic exp_ill;

  main_control dut (
    .clk(clk), .rst(rst), .OpCode(OpCode),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
    .ALUOp1(ALUOp1), .ALUOp0(ALUOp0), .IllegalOp(IllegalOp)
  );

  assign ctrl = {RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp1, ALUOp0};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: classify the instruction, then derive each steering signal from its meaning.
  function automatic logic is_supported(input logic [5:0] op);
    logic addi_ok;
`ifdef CONTROL_ADDI_EN
    addi_ok = 1'b1;
`else
    addi_ok = 1'b0;
`endif
    return (op == 6'd0) || (op == 6'd35) || (op == 6'd43) || (op == 6'd4) || (addi_ok && op == 6'd8);
  endfunction

  function automatic logic [8:0] model(input logic [5:0] op, input logic in_reset);
    logic r, lw, sw, beq, addi;
    r    = (op == 6'd0);
    lw   = (op == 6'd35);
    sw   = (op == 6'd43);
    beq  = (op == 6'd4);
    addi = (op == 6'd8) && is_supported(op);
    if (in_reset) return 9'b0;
    return {r, lw | sw | addi, lw, r | lw | addi, lw, sw, beq, r, beq};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    OpCode = 6'b000000;
    #1;
    checks++;
    if (ctrl !== 9'b0) begin errors++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, 9'b0); end
    checks++;
    if (IllegalOp !== 1'b0) begin errors++; $display("FAIL reset_ill got=%b exp=0", IllegalOp); end
    OpCode = 6'b111111;
    @(posedge clk); #1;
    checks++;
    if (IllegalOp !== 1'b0) begin errors++; $display("FAIL reset_hold_ill got=%b exp=0", IllegalOp); end
    @(negedge clk);
    rst = 1'b0;
    OpCode = 6'b000000;
    #1;
    checks++;
    if (ctrl !== 9'b100100010) begin errors++; $display("FAIL release_rtype got=%b exp=%b", ctrl, 9'b100100010); end
    @(posedge clk); #1;
    checks++;
    if (IllegalOp !== 1'b0) begin errors++; $display("FAIL release_ill got=%b exp=0", IllegalOp); end
    exp_ill = 1'b0;
  endtask

  task automatic test_sequence();
    logic [5:0] seq [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                           6'b100011, 6'b101011, 6'b000100, 6'b000000};
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      OpCode = seq[i];
      #1;
      checks++;
      if (ctrl !== model(seq[i], 1'b0)) begin
        errors++; $display("FAIL seq_ctrl[%0d] op=%b got=%b exp=%b", i, seq[i], ctrl, model(seq[i], 1'b0));
      end
      checks++;
      if (IllegalOp !== 1'b0) begin errors++; $display("FAIL seq_ill[%0d] got=%b exp=0", i, IllegalOp); end
      #4;
    end
  endtask

  task automatic test_illegal_sticky();
    @(negedge clk);
    OpCode = 6'b111111;
    #1;
    checks++;
    if (ctrl !== 9'b0) begin errors++; $display("FAIL illegal_ctrl got=%b exp=%b", ctrl, 9'b0); end
    @(posedge clk); #1;
    checks++;
    if (IllegalOp !== 1'b1) begin errors++; $display("FAIL illegal_set got=%b exp=1", IllegalOp); end
    @(negedge clk);
    OpCode = 6'b100011;
    #1;
    checks++;
    if (ctrl !== 9'b011110000) begin errors++; $display("FAIL after_illegal_lw got=%b exp=%b", ctrl, 9'b011110000); end
    @(posedge clk); #1;
    checks++;
    if (IllegalOp !== 1'b1) begin errors++; $display("FAIL illegal_sticky got=%b exp=1", IllegalOp); end
  endtask

  task automatic test_async_clear();
    @(negedge clk);
    OpCode = 6'b100011;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (IllegalOp !== 1'b0) begin errors++; $display("FAIL async_clear got=%b exp=0", IllegalOp); end
    checks++;
    if (ctrl !== 9'b0) begin errors++; $display("FAIL async_ctrl_zero got=%b exp=%b", ctrl, 9'b0); end
    OpCode = 6'b111111;
    #1 rst = 1'b0;
    checks++;
    if (IllegalOp !== 1'b0) begin errors++; $display("FAIL deassert_nosample got=%b exp=0", IllegalOp); end
    @(posedge clk); #1;
    checks++;
    if (IllegalOp !== 1'b1) begin errors++; $display("FAIL first_edge_sample got=%b exp=1", IllegalOp); end
  endtask

  task automatic test_addi();
    logic [8:0] exp_c;
    logic       exp_i;
    @(negedge clk);
    rst = 1'b1;
    #1 rst = 1'b0;
    OpCode = 6'b001000;
    exp_c = model(6'b001000, 1'b0);
    exp_i = ~is_supported(6'b001000);
    #1;
    checks++;
    if (ctrl !== exp_c) begin errors++; $display("FAIL addi_ctrl got=%b exp=%b", ctrl, exp_c); end
    @(posedge clk); #1;
    checks++;
    if (IllegalOp !== exp_i) begin errors++; $display("FAIL addi_ill got=%b exp=%b", IllegalOp, exp_i); end
  endtask

  task automatic test_glitch_between_edges();
    @(negedge clk);
    rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      OpCode = 6'b111111;
      #1;
      checks++;
      if (ctrl !== 9'b0) begin errors++; $display("FAIL glitch_ctrl[%0d] got=%b exp=%b", i, ctrl, 9'b0); end
      OpCode = 6'b100011;
      @(posedge clk); #1;
      checks++;
      if (IllegalOp !== 1'b0) begin errors++; $display("FAIL glitch_ill[%0d] got=%b exp=0", i, IllegalOp); end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_random();
    logic [5:0] pool [5] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8};
    logic [5:0] op;
    @(negedge clk);
    rst = 1'b1;
    #1 rst = 1'b0;
    exp_ill = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        #1 rst = 1'b1;
        #1;
        exp_ill = 1'b0;
        checks++;
        if (IllegalOp !== 1'b0) begin errors++; $display("FAIL rand_rst_ill[%0d] got=%b exp=0", i, IllegalOp); end
        rst = 1'b0;
      end
      if ($urandom_range(0, 3) != 0) op = pool[$urandom_range(0, 4)];
      else op = 6'($urandom);
      OpCode = op;
      #1;
      checks++;
      if (ctrl !== model(op, 1'b0)) begin
        errors++; $display("FAIL rand_ctrl[%0d] op=%b got=%b exp=%b", i, op, ctrl, model(op, 1'b0));
      end
      @(posedge clk);
      if (!is_supported(op)) exp_ill = 1'b1;
      #1;
      checks++;
      if (IllegalOp !== exp_ill) begin
        errors++; $display("FAIL rand_ill[%0d] op=%b got=%b exp=%b", i, op, IllegalOp, exp_ill);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    OpCode = 6'b0;
    exp_ill = 1'b0;
    test_reset();
    test_sequence();
    test_illegal_sticky();
    test_async_clear();
    test_addi();
    test_glitch_between_edges();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
